// File: rtl/memory_pkg.sv
// Shared encodings and limits for the memory responder and its RAM.
package memory_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 8;
    // Wide enough to hold READ_LAT_MAX-1 with headroom.
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    typedef struct packed {
        logic write;
        logic err;
    } txn_flags_t;

    function automatic bit read_lat_ok(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/memory_responder_ram_sp.sv
// Single-port synchronous RAM: write-enable, registered read, no reset on contents.
module ram_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        // Read register only updates when asked, so it holds through a stalled response.
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: one transaction in flight, configurable read latency,
// out-of-range accesses answered with rsp_err and zero data.
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int              RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);
    localparam bit              LAT_OK   = read_lat_ok(READ_LAT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    txn_flags_t        flags_q, flags_d;

    logic              accept;
    logic              req_err;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    assign accept  = req_valid && (state_q == IDLE);
    // Extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
    assign req_err = ({1'b0, req_addr} >= DEPTH_L);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                ram_addr = req_addr;
                if (accept) begin
                    flags_d = '{write: req_write, err: req_err};
                    if (req_write) begin
                        ram_we  = !req_err;
                        state_d = RESP;
                    end else if (READ_LAT <= 1 || !LAT_OK) begin
                        ram_re  = !req_err;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    ram_re  = !flags_q.err;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    flags_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            if (accept) addr_q <= req_addr;
        end
    end

    ram_sp #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .AW    (RAM_AW)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr[RAM_AW-1:0]),
        .wdata(req_wdata),
        .rdata(ram_q)
    );

    // Address bits above the RAM index only feed the range check.
    generate
        if (RAM_AW < ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^ram_addr[ADDR_W-1:RAM_AW];
        end
    endgenerate

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_err   = rsp_valid && flags_q.err;
    // RAM read register is not reset; mask it so only a good read response exposes it.
    assign rsp_rdata = (rsp_valid && !flags_q.write && !flags_q.err) ? ram_q : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (DEPTH=128, READ_LAT=2).
`timescale 1ns/1ps
module tb_memory_responder;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 128;
    localparam int READ_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    memory_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .READ_LAT(READ_LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Write with rsp_ready=1: accept, response, back to idle.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        issue(1'b1, a, d);
        step();
        req_valid = 1'b0;
        step();
    endtask

    // Read with rsp_ready=1, checking the response in the READ_LAT-th cycle.
    task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp_d, input logic exp_e);
        issue(1'b0, a, '0);
        step();
        req_valid = 1'b0;
        step();
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"},  rsp_rdata, exp_d);
        chk({tag, "_err"},   rsp_err,   exp_e);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_busy",      busy,      1'b0);
        reset = 1'b1;
        step();

        rsp_ready = 1'b1;
        wr(8'h00, 8'h77);
        wr(8'h7F, 8'h5A);

        // Write: response one cycle after accept, busy for one cycle.
        issue(1'b1, 8'h10, 8'hA5);
        step();
        req_valid = 1'b0;
        chk("wr_valid", rsp_valid, 1'b1);
        chk("wr_err",   rsp_err,   1'b0);
        chk("wr_rdata", rsp_rdata, 8'h00);
        chk("wr_busy",  busy,      1'b1);
        chk("wr_ready", req_ready, 1'b0);
        step();
        chk("wr_done_valid", rsp_valid, 1'b0);
        chk("wr_done_busy",  busy,      1'b0);
        chk("wr_done_ready", req_ready, 1'b1);

        // Read: response two cycles after accept.
        issue(1'b0, 8'h10, 8'h00);
        step();
        req_valid = 1'b0;
        chk("rd_c1_valid", rsp_valid, 1'b0);
        chk("rd_c1_ready", req_ready, 1'b0);
        chk("rd_c1_busy",  busy,      1'b1);
        step();
        chk("rd_c2_valid", rsp_valid, 1'b1);
        chk("rd_c2_data",  rsp_rdata, 8'hA5);
        chk("rd_c2_err",   rsp_err,   1'b0);
        chk("rd_c2_ready", req_ready, 1'b0);
        step();
        chk("rd_done_valid", rsp_valid, 1'b0);

        // Out-of-range write and read at DEPTH; neighbours untouched.
        issue(1'b1, 8'h80, 8'h3C);
        step();
        req_valid = 1'b0;
        chk("ewr_valid", rsp_valid, 1'b1);
        chk("ewr_err",   rsp_err,   1'b1);
        chk("ewr_rdata", rsp_rdata, 8'h00);
        step();
        rd_check("erd_80", 8'h80, 8'h00, 1'b1);
        rd_check("rd_7f",  8'h7F, 8'h5A, 1'b0);
        rd_check("rd_00",  8'h00, 8'h77, 1'b0);

        // Stalled response with ignored request pulses.
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 8'h00);
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data",  rsp_rdata, 8'hA5);
            chk("stall_err",   rsp_err,   1'b0);
            chk("stall_ready", req_ready, 1'b0);
            issue(1'b1, 8'h10, 8'hFF);
            req_valid = (i % 2 == 0);
            step();
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("stall_done_valid", rsp_valid, 1'b0);
        rd_check("stall_ram", 8'h10, 8'hA5, 1'b0);

        // Reset one cycle after a read accept abandons the read.
        issue(1'b0, 8'h7F, 8'h00);
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mr_ready", req_ready, 1'b1);
        chk("mr_valid", rsp_valid, 1'b0);
        chk("mr_busy",  busy,      1'b0);
        chk("mr_rdata", rsp_rdata, 8'h00);
        chk("mr_err",   rsp_err,   1'b0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_no_rsp", rsp_valid, 1'b0);
        end
        rd_check("mr_reread", 8'h7F, 8'h5A, 1'b0);

        // Back-to-back write then read with req_valid held high.
        issue(1'b1, 8'h00, 8'h11);
        step();
        req_write = 1'b0;
        req_wdata = 8'h00;
        chk("bb_w_valid", rsp_valid, 1'b1);
        chk("bb_w_ready", req_ready, 1'b0);
        step();
        chk("bb_gap_ready", req_ready, 1'b1);
        chk("bb_gap_busy",  busy,      1'b0);
        step();
        req_valid = 1'b0;
        chk("bb_rd_busy",  busy,      1'b1);
        chk("bb_rd_valid", rsp_valid, 1'b0);
        step();
        chk("bb_rd_valid2", rsp_valid, 1'b1);
        chk("bb_rd_data",   rsp_rdata, 8'h11);
        step();
        chk("bb_end_ready", req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the processor's control unit.
- Serves the opcode/operand fetches and result stores that the control unit initiates after loading MAR/MARR.
- Holds a byte-addressable single-port RAM behind a valid/ready request channel and a valid/ready response channel.
- Read latency is configurable; out-of-range accesses are flagged.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- READ_LAT, 2, cycles from read acceptance to rsp_valid; legal range 1..8.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; latency counter = 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - RAM contents are not reset.
- Handshakes:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - A response completes on a rising edge with rsp_valid && rsp_ready.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, write and wdata, and evaluate err = (req_addr >= DEPTH).
  - Write, err=0: RAM[addr] <= wdata on the accept edge; next state RESP with rsp_rdata=0, rsp_err=0. Write response is visible 1 cycle after accept.
  - Write, err=1: no RAM update; next state RESP with rsp_err=1, rsp_rdata=0.
  - Read, READ_LAT=1: next state RESP with rsp_rdata=RAM[addr] (0 if err) and rsp_err=err.
  - Read, READ_LAT>1: next state RD_WAIT; counter loads READ_LAT-1.
- RD_WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 1, the next edge loads rsp_rdata/rsp_err and enters RESP.
  - rsp_valid therefore rises exactly READ_LAT cycles after the accept edge.
  - Read data is sampled from RAM on that final edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable while rsp_ready=0 (no limit on stall length).
  - On rsp_valid && rsp_ready, return to IDLE, clear rsp_valid, rsp_rdata and rsp_err.
  - req_ready reasserts the following cycle, so minimum request spacing = latency + 1.
- Boundary conditions:
  - req_valid while req_ready=0: ignored, no side effects; the initiator must hold it.
  - Reset asserted mid-read or mid-response: transaction abandoned, no response ever issued. A write already accepted stays committed.
  - Read-after-write to the same address: returns the new data (the write commits before any later accept).
  - Address exactly DEPTH-1: valid. Address DEPTH: error.
- Only one transaction is ever in flight; there is no pipelining across requests.

Decomposition:
- Shared package memory_pkg:
  - state encoding constants: IDLE=2'd0, RD_WAIT=2'd1, RESP=2'd2.
  - default widths ADDR_W=8, DATA_W=8.
  - READ_LAT legal bounds.
- One natural sub-module: ram_sp, a single-port synchronous RAM (DEPTH x DATA_W, write enable, registered read, no reset).
- FSM, counter and error check stay in memory_responder.

Test Plan:
- Reset, then write addr 8'h10 data 8'hA5 with rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_err=0, rsp_rdata=0; busy high for 1 cycle.
- READ_LAT=2: read 8'h10 -> rsp_valid exactly 2 cycles after accept, rsp_rdata=8'hA5; req_ready low during RD_WAIT and RESP.
- DEPTH=128: write 8'h80 data 8'h3C, then read 8'h80 -> both responses have rsp_err=1, read data=0; read of 8'h7F returns its prior contents, unaffected.
- Read with rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable for all 5 cycles; req_valid pulses during the stall are ignored with no RAM change.
- Assert reset one cycle after accepting a read -> rsp_valid never rises; all outputs return to reset values; a subsequent read returns the correct stored data.
- Back-to-back write 8'h00=8'h11 then read 8'h00 with req_valid held high -> second accept occurs one cycle after the first response completes; read returns 8'h11.
